// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select codes, hazard FSM states and
// the width of the load-use wait counter.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } hz_state_t;

  // Wide enough for the largest load latency (4), whose counter starts at 2
  localparam int WAIT_CNT_W = 2;

endpackage

// File: rtl/fwd_match.sv
// Priority comparator for one Execute-stage source operand. The Memory stage
// holds the younger result, so it wins over Writeback. Register x0 never
// forwards because it is hard-wired to zero.
module fwd_match
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_regwrite_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_w,
  output fwd_sel_t          o_sel
);

  // Pick the youngest in-flight producer of this source register
  always_comb begin
    o_sel = FWD_RF;
    if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs)) begin
      o_sel = FWD_W;
    end
    if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs)) begin
      o_sel = FWD_M;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall sequencing
// for multi-cycle data-memory reads, branch flushes and saturating
// stall/flush performance counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] rs_d,
  input  logic [NUM_SRC*REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0]         rd_e,
  input  logic [REG_AW-1:0]         rd_m,
  input  logic [REG_AW-1:0]         rd_w,
  input  logic                      regwrite_m,
  input  logic                      regwrite_w,
  input  logic                      load_e,
  input  logic                      pcsrc_e,
  input  logic                      clr_cnt,
  output logic [NUM_SRC*2-1:0]      fwd_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      busy,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  // The hit cycle itself is the first stall cycle, so the counter covers
  // the remaining LOAD_LAT-1 cycles and exits when it reads zero.
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    WAIT_CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  hz_state_t             r_state;
  hz_state_t             w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait;
  logic [WAIT_CNT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic                  w_rs_hit;
  logic                  w_lu_hit;
  logic                  w_stall;
  fwd_sel_t              w_sel [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    fwd_match #(
      .REG_AW(REG_AW)
    ) u_fwd_match (
      .i_rs        (rs_e[gi*REG_AW +: REG_AW]),
      .i_rd_m      (rd_m),
      .i_regwrite_m(regwrite_m),
      .i_rd_w      (rd_w),
      .i_regwrite_w(regwrite_w),
      .o_sel       (w_sel[gi])
    );
    assign fwd_e[gi*2 +: 2] = w_sel[gi];
  end

  // Load-use detection; only looked at from IDLE and never under a redirect
  always_comb begin
    w_rs_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_d[i*REG_AW +: REG_AW] == rd_e) begin
        w_rs_hit = 1'b1;
      end
    end
    w_lu_hit = load_e && (rd_e != '0) && w_rs_hit && !pcsrc_e && (r_state == IDLE);
  end

  // Stall/flush outputs straight from inputs and current state
  always_comb begin
    w_stall = !pcsrc_e && ((r_state == LOAD_WAIT) || w_lu_hit);
    stall_f = w_stall;
    stall_d = w_stall;
    flush_d = pcsrc_e;
    flush_e = w_stall || pcsrc_e;
    busy    = (r_state == LOAD_WAIT);
  end

  // Next-state logic; a taken branch always aborts any pending wait
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      IDLE: begin
        if (w_lu_hit && (LOAD_LAT > 1)) begin
          w_state_nxt = LOAD_WAIT;
          w_wait_nxt  = WAIT_INIT;
        end
      end
      LOAD_WAIT: begin
        if (r_wait == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt = r_wait - WAIT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
    endcase
    if (pcsrc_e) begin
      w_state_nxt = IDLE;
      w_wait_nxt  = '0;
    end
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (pcsrc_e && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Three instances with load latencies
// 1, 3 and 4 (4-bit counters) share one set of inputs and are compared each
// cycle against a behavioural model that tracks "stall cycles still owed".
module tb_hazard_ctrl;

  logic            clk;
  logic            rst_n;
  logic [9:0]      rsD;
  logic [9:0]      rsE;
  logic [4:0]      rdE;
  logic [4:0]      rdM;
  logic [4:0]      rdW;
  logic            regwriteM;
  logic            regwriteW;
  logic            loadE;
  logic            pcsrcE;
  logic            clrCnt;

  logic [2:0][3:0] fwdE;
  logic [2:0]      stallF;
  logic [2:0]      stallD;
  logic [2:0]      flushD;
  logic [2:0]      flushE;
  logic [2:0]      busyO;
  logic [2:0][3:0] stallCnt;
  logic [2:0][3:0] flushCnt;

  int vectorCount;
  int missCount;
  int stallSeen;

  // Model state per instance
  int latM [3];
  int remM [3];
  int sCntM [3];
  int fCntM [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    hazard_ctrl #(
      .REG_AW  (5),
      .NUM_SRC (2),
      .LOAD_LAT((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
      .CNT_W   (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs_d      (rsD),
      .rs_e      (rsE),
      .rd_e      (rdE),
      .rd_m      (rdM),
      .rd_w      (rdW),
      .regwrite_m(regwriteM),
      .regwrite_w(regwriteW),
      .load_e    (loadE),
      .pcsrc_e   (pcsrcE),
      .clr_cnt   (clrCnt),
      .fwd_e     (fwdE[gi]),
      .stall_f   (stallF[gi]),
      .stall_d   (stallD[gi]),
      .flush_d   (flushD[gi]),
      .flush_e   (flushE[gi]),
      .busy      (busyO[gi]),
      .stall_cnt (stallCnt[gi]),
      .flush_cnt (flushCnt[gi])
    );
  end

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected forward code for one Execute source: Memory beats Writeback
  function automatic logic [1:0] expFwd(input int slot);
    logic [4:0] rs;
    rs = rsE[slot*5 +: 5];
    if (regwriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit luHit();
    return loadE && (rdE != 5'd0) && ((rsD[4:0] == rdE) || (rsD[9:5] == rdE));
  endfunction

  function automatic int satAdd(input int v, input int inc);
    return (v + inc > 15) ? 15 : v + inc;
  endfunction

  // One cycle: inputs already driven just after the edge; check mid-cycle,
  // then advance the model across the next rising edge.
  task automatic applyStimulus();
    int nRem [3];
    int nS [3];
    int nF [3];
    bit st;
    bit bz;
    #3;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        remM[i] = 0; sCntM[i] = 0; fCntM[i] = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      bz = (remM[i] > 0);
      st = !pcsrcE && (bz || luHit());
      checkOutput($sformatf("fwd0[%0d]", i), 32'(fwdE[i][1:0]), 32'(expFwd(0)));
      checkOutput($sformatf("fwd1[%0d]", i), 32'(fwdE[i][3:2]), 32'(expFwd(1)));
      checkOutput($sformatf("stall_f[%0d]", i), 32'(stallF[i]), 32'(st));
      checkOutput($sformatf("stall_d[%0d]", i), 32'(stallD[i]), 32'(st));
      checkOutput($sformatf("flush_d[%0d]", i), 32'(flushD[i]), 32'(pcsrcE));
      checkOutput($sformatf("flush_e[%0d]", i), 32'(flushE[i]), 32'(st || pcsrcE));
      checkOutput($sformatf("busy[%0d]", i), 32'(busyO[i]), 32'(bz));
      checkOutput($sformatf("stall_cnt[%0d]", i), 32'(stallCnt[i]), 32'(sCntM[i]));
      checkOutput($sformatf("flush_cnt[%0d]", i), 32'(flushCnt[i]), 32'(fCntM[i]));
      if (pcsrcE) nRem[i] = 0;
      else if (bz) nRem[i] = remM[i] - 1;
      else if (st) nRem[i] = latM[i] - 1;
      else nRem[i] = 0;
      nS[i] = clrCnt ? 0 : satAdd(sCntM[i], int'(st));
      nF[i] = clrCnt ? 0 : satAdd(fCntM[i], int'(pcsrcE));
    end
    if (stallF[1]) stallSeen++;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        remM[i] = nRem[i]; sCntM[i] = nS[i]; fCntM[i] = nF[i];
      end
    end
    #1;
  endtask

  task automatic quietInputs();
    rsD = '0; rsE = '0; rdE = '0; rdM = '0; rdW = '0;
    regwriteM = 1'b0; regwriteW = 1'b0; loadE = 1'b0; pcsrcE = 1'b0; clrCnt = 1'b0;
  endtask

  task automatic loadUse();
    loadE = 1'b1; rdE = 5'd7; rsD = {5'd7, 5'd3};
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    stallSeen   = 0;
    latM = '{1, 3, 4};
    for (int i = 0; i < 3; i++) begin
      remM[i] = 0; sCntM[i] = 0; fCntM[i] = 0;
    end
    quietInputs();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_busy[%0d]", i), 32'(busyO[i]), 32'd0);
      checkOutput($sformatf("rst_scnt[%0d]", i), 32'(stallCnt[i]), 32'd0);
      checkOutput($sformatf("rst_fcnt[%0d]", i), 32'(flushCnt[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus();

    // Forwarding priority: Memory over Writeback, x0 excluded
    rsE = {5'd0, 5'd5}; rdM = 5'd5; regwriteM = 1'b1; rdW = 5'd5; regwriteW = 1'b1;
    #3;
    checkOutput("fwd_mem_wins", 32'(fwdE[0][1:0]), 32'd2);
    #2;
    rdM = 5'd0;
    #1;
    checkOutput("fwd_wb_when_rdm0", 32'(fwdE[0][1:0]), 32'd1);
    @(posedge clk);
    #1;
    quietInputs();

    // Load-use with 3-cycle latency
    stallSeen = 0;
    loadUse();
    applyStimulus();
    quietInputs();
    checkOutput("ll3_busy_c2", 32'(busyO[1]), 32'd1);
    for (int c = 0; c < 4; c++) applyStimulus();
    checkOutput("ll3_stall_len", 32'(stallSeen), 32'd3);
    checkOutput("ll3_stall_cnt", 32'(stallCnt[1]), 32'd3);

    // Load-use hit under a taken branch
    clrCnt = 1'b1;
    applyStimulus();
    quietInputs();
    loadUse();
    pcsrcE = 1'b1;
    #3;
    checkOutput("br_stall_f", 32'(stallF[1]), 32'd0);
    checkOutput("br_flush_d", 32'(flushD[1]), 32'd1);
    #1;
    applyStimulus();
    quietInputs();
    #3;
    checkOutput("br_busy", 32'(busyO[2]), 32'd0);
    checkOutput("br_flush_cnt", 32'(flushCnt[1]), 32'd1);
    #1;
    applyStimulus();

    // Saturation on the 1-cycle instance, then clear
    loadUse();
    for (int c = 0; c < 20; c++) applyStimulus();
    quietInputs();
    applyStimulus();
    checkOutput("sat_stall_cnt", 32'(stallCnt[0]), 32'd15);
    clrCnt = 1'b1;
    applyStimulus();
    clrCnt = 1'b0;
    applyStimulus();
    checkOutput("clr_stall_cnt", 32'(stallCnt[0]), 32'd0);

    // x0 destination never stalls
    loadE = 1'b1; rdE = 5'd0; rsD = '0;
    #3;
    checkOutput("x0_no_stall", 32'(stallF[2]), 32'd0);
    #1;
    applyStimulus();
    quietInputs();
    for (int c = 0; c < 4; c++) applyStimulus();

    // Reset during the second LOAD_WAIT cycle of the 4-cycle instance
    loadUse();
    applyStimulus();
    quietInputs();
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busyO[2]), 32'd0);
    checkOutput("arst_stall", 32'(stallF[2]), 32'd0);
    checkOutput("arst_scnt", 32'(stallCnt[2]), 32'd0);
    #1;
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("arst_no_stall", 32'(stallF[2]), 32'd0);

    // Randomized traffic with small register numbers to provoke matches
    for (int c = 0; c < 400; c++) begin
      rsD = {2'b00, 3'($urandom), 2'b00, 3'($urandom)};
      rsE = {2'b00, 3'($urandom), 2'b00, 3'($urandom)};
      rdE = {2'b00, 3'($urandom)};
      rdM = {2'b00, 3'($urandom)};
      rdW = {2'b00, 3'($urandom)};
      regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      loadE     = 1'($urandom);
      pcsrcE    = ($urandom_range(0, 7) == 0);
      clrCnt    = ($urandom_range(0, 19) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width (32 architectural registers max; x0 hard-wired zero).
REQ-002 Parameter NUM_SRC, default 2, legal 2..3: source operands per instruction.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..4: data-memory read latency in cycles; equals load-use stall length.
REQ-004 Parameter CNT_W, default 16: width of performance counters.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, reset input 1 (active-low, asynchronous).
REQ-006 rs_d  in  NUM_SRC*REG_AW  source addresses of instruction in Decode; slot i at bits [i*REG_AW +: REG_AW].
REQ-007 rs_e  in  NUM_SRC*REG_AW  source addresses of instruction in Execute.
REQ-008 rd_e, rd_m, rd_w  in  REG_AW each  destination addresses in Execute/Memory/Writeback.
REQ-009 regwrite_m, regwrite_w  in  1  register-write enables in Memory/Writeback.
REQ-010 load_e  in  1  Execute instruction is a load (ResultSrc selects memory).
REQ-011 pcsrc_e  in  1  taken branch/jump resolved in Execute.
REQ-012 clr_cnt  in  1  synchronous clear of both counters.
REQ-013 fwd_e  out  NUM_SRC*2  per-source forward select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-014 stall_f, stall_d  out  1  hold PC and Fetch/Decode register.
REQ-015 flush_d, flush_e  out  1  bubble Fetch/Decode and Decode/Execute registers.
REQ-016 busy  out  1  state is LOAD_WAIT.
REQ-017 stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

Function
REQ-018 fwd_e slot i SHALL be 10 when regwrite_m, rd_m!=0, rd_m==rs_e slot i; else 01 when regwrite_w, rd_w!=0, rd_w==rs_e slot i; else 00 (Memory beats Writeback), combinational.
REQ-019 Load-use hit SHALL be: load_e, rd_e!=0, rd_e equals any rs_d slot.
REQ-020 FSM states IDLE, LOAD_WAIT; IDLE with load-use hit, pcsrc_e=0, LOAD_LAT>1 -> LOAD_WAIT, wait counter loaded LOAD_LAT-2.
REQ-021 In LOAD_WAIT, counter decrements each cycle; counter==0 -> IDLE; load_e/rs_d ignored in LOAD_WAIT.
REQ-022 stall_f=stall_d=flush_e=1 in the load-use hit cycle and every LOAD_WAIT cycle; total stall exactly LOAD_LAT cycles; LOAD_LAT=1 never enters LOAD_WAIT.
REQ-023 pcsrc_e=1 SHALL assert flush_d=flush_e=1 same cycle, force stall_f=stall_d=0, suppress load-use detection, and force next state IDLE (aborts LOAD_WAIT).
REQ-024 stall_cnt SHALL increment once per cycle stall_f=1; flush_cnt once per cycle pcsrc_e=1; both saturate at 2^CNT_W-1, no wrap.
REQ-025 clr_cnt=1 SHALL zero both counters next edge, overriding increment that cycle.
REQ-026 Control outputs combinational from inputs and registered state; no extra latency.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, wait counter 0, stall_cnt=flush_cnt=0, busy=0; stall/flush outputs then depend only on inputs.
REQ-028 Reset asserted mid-LOAD_WAIT SHALL abandon the stall immediately; release resumes in IDLE on next edge.

Structure
REQ-029 Shared package pipeline_pkg SHALL hold fwd_sel_t (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and hz_state_t (IDLE, LOAD_WAIT).
REQ-030 One sub-module fwd_match (per-source priority comparator producing fwd_sel_t) SHALL be instantiated NUM_SRC times via generate.

Verification
REQ-031 rs_e slot0=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_e slot0=10; rd_m=0 same otherwise -> 01.
REQ-032 LOAD_LAT=3, load_e=1, rd_e=7, rs_d slot1=7 -> stall_f/stall_d/flush_e high exactly 3 cycles, busy high cycles 2-3, stall_cnt=3.
REQ-033 Same load-use hit with pcsrc_e=1 -> flush_d=flush_e=1, stall_f=0, state stays IDLE, flush_cnt=1.
REQ-034 CNT_W=4, 20 consecutive stall cycles -> stall_cnt holds 15; clr_cnt pulse -> 0.
REQ-035 LOAD_LAT=4, reset pulled low in second LOAD_WAIT cycle -> busy=0 and counters 0 immediately, no stall after release.
REQ-036 load_e=1, rd_e=0, rs_d slot0=0 -> no stall.
